cmp_minmax_tracker: RTL

//  Windowed running max/min tracker built around the 4-bit magnitude comparator.
//  - Accepts a stream of unsigned samples over a valid/ready handshake.
//  - Drives each sample into two comparator instances: sample vs current max, and sample vs current min.
//  - After WINDOW samples, or on flush, presents max, min, all-equal flag and sample count on a registered valid/ready output.
//  - Sits directly downstream of the comparator, consuming its flags.

---
 rtl/cmp_minmax_tracker_pkg.sv | 12 +
 rtl/cmp_minmax_tracker_cmp.sv | 19 +
 rtl/cmp_minmax_tracker.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/cmp_minmax_tracker_pkg.sv
// Shared constants for the windowed max/min tracker: FSM state encoding and
// default sample width / window length.
package cmp_minmax_tracker_pkg;

    localparam int DEF_W      = 4;
    localparam int DEF_WINDOW = 8;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

endpackage

// File: rtl/cmp_minmax_tracker_cmp.sv
// Unsigned magnitude comparator (A vs B). Defaults to 4 bits; the width
// parameter lets the same port order serve other sample widths.
module comparatorBehavior4bits
    import cmp_minmax_tracker_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         AeqB,
    output logic         AgeqB,
    output logic         AltB
);

    assign AeqB  = (A == B);
    assign AgeqB = (A >= B);
    assign AltB  = (A <  B);

endmodule

// File: rtl/cmp_minmax_tracker.sv
// Windowed running max/min tracker: accumulates up to WINDOW unsigned samples
// and presents max, min, all-equal flag and count on a registered output.
module cmp_minmax_tracker
    import cmp_minmax_tracker_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int WINDOW = DEF_WINDOW,
    parameter int CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_max,
    output logic [W-1:0]     out_min,
    output logic             out_eq_all,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [CNT_W-1:0] WIN_CNT = CNT_W'(WINDOW);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       state_r, state_nxt_s;
    logic [CNT_W-1:0] count_r, count_nxt_s;
    logic [W-1:0]     max_r, max_nxt_s;
    logic [W-1:0]     min_r, min_nxt_s;
    logic             eq_r, eq_nxt_s;
    logic             load_out_s;
    logic             accept_s;

    logic             max_eq_s, max_ge_s, max_lt_s;
    logic             min_eq_s, min_ge_s, min_lt_s;

    logic             out_valid_r;
    logic [W-1:0]     out_max_r, out_min_r;
    logic             out_eq_r;
    logic [CNT_W-1:0] out_count_r;

    comparatorBehavior4bits #(.W(W)) u_cmp_max (
        .A     (in_data),
        .B     (max_r),
        .AeqB  (max_eq_s),
        .AgeqB (max_ge_s),
        .AltB  (max_lt_s)
    );

    comparatorBehavior4bits #(.W(W)) u_cmp_min (
        .A     (in_data),
        .B     (min_r),
        .AeqB  (min_eq_s),
        .AgeqB (min_ge_s),
        .AltB  (min_lt_s)
    );

    assign in_ready = (state_r != ST_HOLD) && !clear;
    assign accept_s = in_valid && in_ready;

    // Next-state and datapath update; a clear overrides everything else.
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        max_nxt_s   = max_r;
        min_nxt_s   = min_r;
        eq_nxt_s    = eq_r;
        load_out_s  = 1'b0;
        if (clear) begin
            state_nxt_s = ST_EMPTY;
            count_nxt_s = '0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        max_nxt_s   = in_data;
                        min_nxt_s   = in_data;
                        eq_nxt_s    = 1'b1;
                        count_nxt_s = CNT_ONE;
                        if (WINDOW == 1) begin
                            state_nxt_s = ST_HOLD;
                            load_out_s  = 1'b1;
                        end else begin
                            state_nxt_s = ST_ACCUM;
                        end
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_ACCUM: begin
                    if (accept_s) begin
                        // Complementary flags must agree before a register moves.
                        if (max_ge_s && !max_lt_s) begin
                            max_nxt_s = in_data;
                        end else begin
                            max_nxt_s = max_r;
                        end
                        if (min_lt_s && !min_ge_s) begin
                            min_nxt_s = in_data;
                        end else begin
                            min_nxt_s = min_r;
                        end
                        eq_nxt_s    = eq_r && max_eq_s && min_eq_s;
                        count_nxt_s = count_r + CNT_ONE;
                    end else begin
                        count_nxt_s = count_r;
                    end
                    if (flush || (accept_s && (count_nxt_s == WIN_CNT))) begin
                        state_nxt_s = ST_HOLD;
                        load_out_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_ACCUM;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_nxt_s = ST_EMPTY;
                        count_nxt_s = '0;
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                    count_nxt_s = '0;
                end
            endcase
        end
    end

    // Window accumulation registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_EMPTY;
            count_r <= '0;
            max_r   <= '0;
            min_r   <= '0;
            eq_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
            max_r   <= max_nxt_s;
            min_r   <= min_nxt_s;
            eq_r    <= eq_nxt_s;
        end
    end

    // Result registers: captured on entry to HOLD, stable until the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_max_r   <= '0;
            out_min_r   <= '0;
            out_eq_r    <= 1'b0;
            out_count_r <= '0;
        end else begin
            out_valid_r <= (state_nxt_s == ST_HOLD);
            if (load_out_s) begin
                out_max_r   <= max_nxt_s;
                out_min_r   <= min_nxt_s;
                out_eq_r    <= eq_nxt_s;
                out_count_r <= count_nxt_s;
            end else begin
                out_max_r   <= out_max_r;
                out_min_r   <= out_min_r;
                out_eq_r    <= out_eq_r;
                out_count_r <= out_count_r;
            end
        end
    end

    assign out_valid  = out_valid_r;
    assign out_max    = out_max_r;
    assign out_min    = out_min_r;
    assign out_eq_all = out_eq_r;
    assign out_count  = out_count_r;

endmodule
